// File: rtl/freq_gauge_multi.sv
// freq_gauge_multi: multi-channel frequency gauge behind a 32-bit Avalon-MM slave.
// Synchronised probe toggle edges are counted over a programmable gate and scaled to Hz.
module freq_gauge_multi #(
  parameter int Channels       = 4,
  parameter int ReferenceClock = 50000000,
  parameter int PrescaleLog2   = 0,
  parameter int SyncStages     = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [Channels-1:0] probe_toggle,
  input  logic [4:0]          mm_address,
  input  logic                mm_read,
  output logic [31:0]         mm_readdata,
  input  logic                mm_write,
  input  logic [31:0]         mm_writedata
);

  localparam int          ProdW    = 32 + PrescaleLog2 + 7;
  localparam logic [31:0] GateFast = 32'(ReferenceClock / 100);
  localparam logic [31:0] GateMid  = 32'(ReferenceClock / 10);
  localparam logic [31:0] GateSlow = 32'(ReferenceClock);

  function automatic logic [31:0] gate_reload(input logic [1:0] sel);
    case (sel)
      2'b01:   gate_reload = GateMid - 32'd1;
      2'b10:   gate_reload = GateSlow - 32'd1;
      default: gate_reload = GateFast - 32'd1;
    endcase
  endfunction

  function automatic logic [6:0] gate_scale(input logic [1:0] sel);
    case (sel)
      2'b01:   gate_scale = 7'd10;
      2'b10:   gate_scale = 7'd1;
      default: gate_scale = 7'd100;
    endcase
  endfunction

  // Bit 32 of the return value flags saturation of the 32-bit result.
  function automatic logic [32:0] to_hz(input logic [31:0] edges, input logic [1:0] sel);
    logic [ProdW-1:0] prod;
    prod = (ProdW'(edges) << PrescaleLog2) * ProdW'(gate_scale(sel));
    if (prod[ProdW-1:32] != '0) begin
      to_hz = {1'b1, 32'hFFFF_FFFF};
    end else begin
      to_hz = {1'b0, prod[31:0]};
    end
  endfunction

  logic [Channels-1:0] sync_q [SyncStages];
  logic [Channels-1:0] sync_d [SyncStages];
  logic [Channels-1:0] cmp_q, cmp_d, edge_s;
  logic [2:0]          ctrl_q, ctrl_d;
  logic [31:0]         gate_q, gate_d;
  logic [31:0]         cnt_q [Channels];
  logic [31:0]         cnt_d [Channels];
  logic [31:0]         res_q [Channels];
  logic [31:0]         res_d [Channels];
  logic [Channels-1:0] valid_q, valid_d, ovf_q, ovf_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                ctrl_wr_s;
  logic                unused_wdata_s;

  assign ctrl_wr_s      = mm_write && (mm_address == 5'd0);
  assign edge_s         = sync_q[SyncStages-1] ^ cmp_q;
  assign mm_readdata    = rdata_q;
  assign unused_wdata_s = ^mm_writedata[31:3];

  // Probe synchroniser shift and edge-compare stage.
  always_comb begin
    sync_d[0] = probe_toggle;
    for (int s = 1; s < SyncStages; s++) begin
      sync_d[s] = sync_q[s-1];
    end
    cmp_d = sync_q[SyncStages-1];
  end

  // Gate timing, edge counting and result capture; a CTRL write restarts the window.
  always_comb begin
    ctrl_d  = ctrl_q;
    gate_d  = gate_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    if (ctrl_wr_s) begin
      ctrl_d  = mm_writedata[2:0];
      gate_d  = gate_reload(mm_writedata[2:1]);
      cnt_d   = '{default: 32'd0};
      valid_d = '0;
    end else if (!ctrl_q[0]) begin
      gate_d = gate_reload(ctrl_q[2:1]);
      cnt_d  = '{default: 32'd0};
    end else if (gate_q == 32'd0) begin
      gate_d = gate_reload(ctrl_q[2:1]);
      for (int i = 0; i < Channels; i++) begin
        // An edge seen on the terminal cycle opens the next window.
        cnt_d[i]             = {31'd0, edge_s[i]};
        {ovf_d[i], res_d[i]} = to_hz(cnt_q[i], ctrl_q[2:1]);
        valid_d[i]           = 1'b1;
      end
    end else begin
      gate_d = gate_q - 32'd1;
      for (int i = 0; i < Channels; i++) begin
        cnt_d[i] = (edge_s[i] && (cnt_q[i] != 32'hFFFF_FFFF)) ? cnt_q[i] + 32'd1 : cnt_q[i];
      end
    end
  end

  // Register read mux; reads see pre-write, pre-update state.
  always_comb begin
    rdata_d = 32'd0;
    if (mm_read) begin
      case (mm_address)
        5'd0:    rdata_d = {29'd0, ctrl_q};
        5'd1:    rdata_d = {16'(ovf_q), 16'(valid_q)};
        default: begin
          for (int i = 0; i < Channels; i++) begin
            rdata_d = (mm_address == 5'(i + 2)) ? res_q[i] : rdata_d;
          end
        end
      endcase
    end else begin
      rdata_d = 32'd0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '{default: '0};
      cmp_q   <= '0;
      ctrl_q  <= 3'b001;
      gate_q  <= GateFast - 32'd1;
      cnt_q   <= '{default: 32'd0};
      res_q   <= '{default: 32'hFFFF_FFFF};
      valid_q <= '0;
      ovf_q   <= '0;
      rdata_q <= 32'd0;
    end else begin
      sync_q  <= sync_d;
      cmp_q   <= cmp_d;
      ctrl_q  <= ctrl_d;
      gate_q  <= gate_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_freq_gauge_multi.sv
// Bench for freq_gauge_multi: two instances (prescale 0 and 28) share stimulus and are
// checked against a model that counts logged probe edges inside each gate window.
module tb_freq_gauge_multi;

  localparam int Ch     = 4;
  localparam int RefClk = 100000;
  localparam int SyncN  = 3;
  localparam int PBig   = 28;
  localparam int Never  = 2147483647;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [Ch-1:0] probe;
  logic [4:0]    mm_address;
  logic          mm_read;
  logic          mm_write;
  logic [31:0]   mm_writedata;
  logic [31:0]   rd_a, rd_b;

  always #5 clk = ~clk;

  freq_gauge_multi #(.Channels(Ch), .ReferenceClock(RefClk), .PrescaleLog2(0), .SyncStages(SyncN)) dut_a (
    .clk(clk), .reset_n(reset_n), .probe_toggle(probe), .mm_address(mm_address), .mm_read(mm_read),
    .mm_readdata(rd_a), .mm_write(mm_write), .mm_writedata(mm_writedata));

  freq_gauge_multi #(.Channels(Ch), .ReferenceClock(RefClk), .PrescaleLog2(PBig), .SyncStages(SyncN)) dut_b (
    .clk(clk), .reset_n(reset_n), .probe_toggle(probe), .mm_address(mm_address), .mm_read(mm_read),
    .mm_readdata(rd_b), .mm_write(mm_write), .mm_writedata(mm_writedata));

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int period   [Ch];
  int force_at [Ch];
  int ev_cyc [$];
  int ev_ch  [$];
  int win_lo, next_t, gate_g;
  longint kmul;
  logic [31:0] exp_res_a [Ch];
  logic [31:0] exp_res_b [Ch];
  logic [31:0] last_a [Ch];
  logic [31:0] last_b [Ch];
  logic [Ch-1:0] exp_valid, exp_ovf_a, exp_ovf_b;
  logic [2:0] exp_ctrl;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
  endtask

  function automatic int gsize(input logic [1:0] sel);
    case (sel)
      2'b01:   return RefClk / 10;
      2'b10:   return RefClk;
      default: return RefClk / 100;
    endcase
  endfunction

  function automatic longint kval(input logic [1:0] sel);
    case (sel)
      2'b01:   return 64'd10;
      2'b10:   return 64'd1;
      default: return 64'd100;
    endcase
  endfunction

  // Hz = edges * 2^p * K, saturated to 32 bits; bit 32 is the overflow flag.
  function automatic logic [32:0] expect_hz(input longint n, input int p, input longint k);
    longint v;
    v = (n << p) * k;
    if (v > 64'h0000_0000_FFFF_FFFF) return {1'b1, 32'hFFFF_FFFF};
    return {1'b0, v[31:0]};
  endfunction

  // One clock: land just after the edge, drop strobes, then drive and log probe toggles.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    mm_read  = 1'b0;
    mm_write = 1'b0;
    for (int i = 0; i < Ch; i++) begin
      if ((period[i] > 0 && (cyc % period[i]) == 0) || force_at[i] == cyc) begin
        probe[i] = ~probe[i];
        ev_cyc.push_back(cyc + SyncN);
        ev_ch.push_back(i);
      end
    end
  endtask

  task automatic bus_read(input logic [4:0] addr, output logic [31:0] a, output logic [31:0] b);
    mm_address = addr;
    mm_read    = 1'b1;
    tick();
    a = rd_a;
    b = rd_b;
  endtask

  task automatic bus_write(input logic [31:0] data, input logic rd, output logic [31:0] a, output logic [31:0] b);
    mm_address   = 5'd0;
    mm_write     = 1'b1;
    mm_writedata = data;
    mm_read      = rd;
    tick();
    a         = rd_a;
    b         = rd_b;
    exp_ctrl  = data[2:0];
    exp_valid = '0;
    gate_g    = gsize(data[2:1]);
    kmul      = kval(data[2:1]);
    win_lo    = cyc;
    next_t    = data[0] ? cyc + gate_g - 1 : Never;
    while (ev_cyc.size() > 0 && ev_cyc[0] < cyc) begin
      void'(ev_cyc.pop_front());
      void'(ev_ch.pop_front());
    end
  endtask

  task automatic check_all();
    logic [31:0] a, b;
    bus_read(5'd1, a, b);
    check_eq("stat_a", a, {16'(exp_ovf_a), 16'(exp_valid)});
    check_eq("stat_b", b, {16'(exp_ovf_b), 16'(exp_valid)});
    for (int i = 0; i < Ch; i++) begin
      bus_read(5'(i + 2), a, b);
      check_eq($sformatf("res%0d_a", i), a, exp_res_a[i]);
      check_eq($sformatf("res%0d_b", i), b, exp_res_b[i]);
      last_a[i] = a;
      last_b[i] = b;
    end
  endtask

  // Called in the terminal cycle: a read now must return the previous result.
  task automatic close_window();
    int cnt [Ch];
    logic [31:0] a, b;
    logic [32:0] ea, eb;
    for (int i = 0; i < Ch; i++) cnt[i] = 0;
    for (int j = 0; j < ev_cyc.size(); j++) begin
      if (ev_cyc[j] >= win_lo && ev_cyc[j] < next_t) cnt[ev_ch[j]]++;
    end
    while (ev_cyc.size() > 0 && ev_cyc[0] < next_t) begin
      void'(ev_cyc.pop_front());
      void'(ev_ch.pop_front());
    end
    bus_read(5'd2, a, b);
    check_eq("res0_old_a", a, exp_res_a[0]);
    check_eq("res0_old_b", b, exp_res_b[0]);
    for (int i = 0; i < Ch; i++) begin
      ea = expect_hz(longint'(cnt[i]), 0, kmul);
      eb = expect_hz(longint'(cnt[i]), PBig, kmul);
      exp_res_a[i] = ea[31:0];
      exp_ovf_a[i] = ea[32];
      exp_res_b[i] = eb[31:0];
      exp_ovf_b[i] = eb[32];
    end
    exp_valid = '1;
    win_lo    = next_t;
    next_t    = next_t + gate_g;
    check_all();
  endtask

  task automatic run_windows(input int n);
    repeat (n) begin
      while (cyc < next_t) tick();
      close_window();
    end
  endtask

  task automatic release_reset();
    #2 reset_n = 1'b1;
    exp_ctrl  = 3'b001;
    exp_valid = '0;
    exp_ovf_a = '0;
    exp_ovf_b = '0;
    for (int i = 0; i < Ch; i++) begin
      exp_res_a[i] = 32'hFFFF_FFFF;
      exp_res_b[i] = 32'hFFFF_FFFF;
    end
    gate_g = gsize(2'b00);
    kmul   = kval(2'b00);
    win_lo = cyc;
    next_t = cyc + gate_g - 1;
    ev_cyc.delete();
    ev_ch.delete();
  endtask

  task automatic set_periods(input int p0, input int p1, input int p2, input int p3);
    period[0] = p0;
    period[1] = p1;
    period[2] = p2;
    period[3] = p3;
  endtask

  initial begin
    logic [31:0] a, b, r0, r1;
    logic [2:0]  old_ctrl;
    reset_n      = 1'b0;
    probe        = '0;
    mm_address   = 5'd0;
    mm_read      = 1'b0;
    mm_write     = 1'b0;
    mm_writedata = 32'd0;
    for (int i = 0; i < Ch; i++) begin
      period[i]   = 0;
      force_at[i] = -1;
    end
    repeat (3) tick();
    release_reset();

    // Reset state.
    bus_read(5'd0, a, b);
    check_eq("ctrl_rst_a", a, 32'h1);
    check_eq("ctrl_rst_b", b, 32'h1);
    check_all();
    bus_read(5'd31, a, b);
    check_eq("unmapped_a", a, 32'd0);
    check_eq("unmapped_b", b, 32'd0);

    // Ch0 every 5 clk, 10 ms gate.
    set_periods(5, 0, 0, 0);
    bus_write(32'h1, 1'b0, a, b);
    run_windows(2);
    check_eq("t1_res0", last_a[0], 32'd20000);
    check_eq("t1_valid0", 32'(exp_valid[0]), 32'd1);

    // Prescale 28 overflows, then clears once toggling stops.
    set_periods(2, 0, 0, 0);
    bus_write(32'h1, 1'b0, a, b);
    run_windows(2);
    bus_read(5'd1, a, b);
    check_eq("t3_res0_sat", last_b[0], 32'hFFFF_FFFF);
    check_eq("t3_ovf_set", 32'(b[16]), 32'd1);
    set_periods(0, 0, 0, 0);
    run_windows(2);
    bus_read(5'd1, a, b);
    check_eq("t3_res0_zero", last_b[0], 32'd0);
    check_eq("t3_ovf_clr", 32'(b[16]), 32'd0);

    // Edge one cycle before terminal vs. on the terminal cycle.
    repeat (5) tick();
    bus_write(32'h1, 1'b0, a, b);
    force_at[3] = next_t - 1 - SyncN;
    run_windows(1);
    r0 = last_a[3];
    force_at[3] = next_t - SyncN;
    run_windows(1);
    r1 = last_a[3];
    run_windows(1);
    check_eq("t4_diff_k", r0 - r1, 32'd100);
    check_eq("t4_next_win", last_a[3], 32'd100);
    force_at[3] = -1;

    // Randomised periods and gate encodings 00/11.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < Ch; i++) period[i] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(2, 12));
      bus_write({29'd0, ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00, 1'b1}, 1'b0, a, b);
      run_windows(2);
    end

    // Mid-window CTRL write with a simultaneous CTRL read.
    while (cyc < next_t - 500) tick();
    old_ctrl = exp_ctrl;
    bus_write(32'h1, 1'b1, a, b);
    check_eq("wr_rd_old_a", a, {29'd0, old_ctrl});
    check_eq("wr_rd_old_b", b, {29'd0, old_ctrl});
    check_all();
    run_windows(1);

    // Disabled: results and ovf hold, valid stays clear.
    bus_write(32'h0, 1'b0, a, b);
    repeat (1100) tick();
    check_all();

    // Ch1 every 7 clk, ch2 every 3 clk, 100 ms gate.
    set_periods(0, 7, 3, 0);
    bus_write(32'h3, 1'b0, a, b);
    run_windows(2);
    check_eq("t2_res1_range", 32'(last_a[1] >= 32'd14280 && last_a[1] <= 32'd14290), 32'd1);
    check_eq("t2_res2_range", 32'(last_a[2] >= 32'd33330 && last_a[2] <= 32'd33340), 32'd1);

    // Reset pulse mid-window clears read data asynchronously.
    repeat (300) tick();
    mm_address = 5'd3;
    mm_read    = 1'b1;
    tick();
    #2 reset_n = 1'b0;
    #1;
    check_eq("rst_async_a", rd_a, 32'd0);
    check_eq("rst_async_b", rd_b, 32'd0);
    set_periods(0, 0, 0, 0);
    probe = '0;
    repeat (3) tick();
    release_reset();
    bus_read(5'd0, a, b);
    check_eq("ctrl_rst2_a", a, 32'h1);
    check_eq("ctrl_rst2_b", b, 32'h1);
    check_all();
    bus_read(5'd31, a, b);
    check_eq("unmapped2_a", a, 32'd0);
    set_periods(4, 0, 6, 0);
    run_windows(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
